// File: rtl/aes_dom_pkg.sv
// Shared definitions for the word-level DOM masked S-box front end.
// Randomness widths as functions of the share count d, FSM state encoding,
// byte/share bit index helper and the GF(2^8) helpers used by the masked core.
package aes_dom_pkg;

  // Blinding parameters of the masked inversion; chosen so that the four
  // random buses together carry exactly four GF(2^8) DOM multipliers' worth.
  localparam int BCOEFF = 5;

  function automatic int blind_n_rnd(input int d);
    return d * (d - 1);
  endfunction

  function automatic int rnd_r0(input int d);
    return 2 * d * (d - 1);
  endfunction

  function automatic int rnd_r1(input int d);
    return d * (d - 1);
  endfunction

  function automatic int rnd_r2(input int d);
    return 2 * d * (d - 1) + (2 + BCOEFF) * blind_n_rnd(d);
  endfunction

  function automatic int rnd_r3(input int d);
    return 4 * d * (d - 1);
  endfunction

  // Fresh bits per DOM multiplier: one byte per unordered share pair.
  function automatic int mul_rnd(input int d);
    return 4 * d * (d - 1);
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Bit j of share i of byte b inside a d-share masked vector.
  function automatic int share_bit(input int d, input int b, input int j, input int i);
    return b * 8 * d + j * d + i;
  endfunction

  // Index of the random byte shared by share pair {i, j}, i != j.
  function automatic int pair_idx(input int d, input int i, input int j);
    int lo;
    int hi;
    if (i == j) return 0;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * d - (lo * (lo + 1)) / 2 + (hi - lo - 1);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_sq(input logic [7:0] a);
    return gf_mul(a, a);
  endfunction

  // Linear part of the AES affine map; the 0x63 constant is added by the caller.
  function automatic logic [7:0] affine_lin(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]};
  endfunction

endpackage

// File: rtl/aes_sbox_dom.sv
// Per-byte d-share masked AES S-box, 4-cycle pipeline.
// Inversion as x^254 = four DOM-indep GF(2^8) multiplications, one per stage;
// squarings and the affine map are linear and applied share-wise.
// Ports:
//   clk_i            clock
//   in_i   [8d]      masked byte, bit j share i at j*d+i
//   rnd0_i..rnd3_i   fresh randomness, consumed in the input cycle
//   out_o  [8d]      masked S-box output, same layout, 4 cycles after in_i
module aes_sbox_dom
  import aes_dom_pkg::*;
#(
  parameter int d = 2
) (
  input  logic                   clk_i,
  input  logic [8*d-1:0]         in_i,
  input  logic [rnd_r0(d)-1:0]   rnd0_i,
  input  logic [rnd_r1(d)-1:0]   rnd1_i,
  input  logic [rnd_r2(d)-1:0]   rnd2_i,
  input  logic [rnd_r3(d)-1:0]   rnd3_i,
  output logic [8*d-1:0]         out_o
);

  localparam int MR = mul_rnd(d);

  logic [4*MR-1:0] pool;
  logic [3*MR-1:0] rnd1_q;
  logic [2*MR-1:0] rnd2_q;
  logic [MR-1:0]   rnd3_q;
  logic [MR-1:0]   z_s [4];

  logic [7:0] x_sh   [d];
  logic [7:0] o_sh   [d];
  logic [7:0] x2_q   [3][d];
  logic [7:0] x12_q  [d];
  logic [7:0] a_s    [4][d];
  logic [7:0] b_s    [4][d];
  logic [7:0] c_s    [4][d];
  logic [7:0] t_q    [4][d][d];

  assign pool = {rnd3_i, rnd2_i, rnd1_i, rnd0_i};

  // All randomness of a byte arrives with it; later stages use delayed slices.
  assign z_s[0] = pool[MR-1:0];
  assign z_s[1] = rnd1_q[MR-1:0];
  assign z_s[2] = rnd2_q[MR-1:0];
  assign z_s[3] = rnd3_q;

  // Stage operands: x2*x=x3, x12*x3=x15, x240*x12=x252, x252*x2=x254.
  always_comb begin
    for (int i = 0; i < d; i++) begin
      for (int j = 0; j < 8; j++) x_sh[i][j] = in_i[share_bit(d, 0, j, i)];
      a_s[0][i] = gf_sq(x_sh[i]);
      b_s[0][i] = x_sh[i];
      a_s[1][i] = gf_sq(gf_sq(c_s[0][i]));
      b_s[1][i] = c_s[0][i];
      a_s[2][i] = gf_sq(gf_sq(gf_sq(gf_sq(c_s[1][i]))));
      b_s[2][i] = x12_q[i];
      a_s[3][i] = c_s[2][i];
      b_s[3][i] = x2_q[2][i];
    end
  end

  // Cross-domain products are remasked before the register; the pair byte
  // appears in both domains so it cancels on recombination.
  always_ff @(posedge clk_i) begin
    for (int s = 0; s < 4; s++)
      for (int i = 0; i < d; i++)
        for (int j = 0; j < d; j++)
          t_q[s][i][j] <= gf_mul(a_s[s][i], b_s[s][j]) ^
                          ((i == j) ? 8'h00 : z_s[s][pair_idx(d, i, j)*8 +: 8]);
    rnd1_q <= pool[4*MR-1:MR];
    rnd2_q <= rnd1_q[3*MR-1:MR];
    rnd3_q <= rnd2_q[2*MR-1:MR];
    for (int i = 0; i < d; i++) begin
      x2_q[0][i] <= a_s[0][i];
      x2_q[1][i] <= x2_q[0][i];
      x2_q[2][i] <= x2_q[1][i];
      x12_q[i]   <= a_s[1][i];
    end
  end

  always_comb begin
    for (int s = 0; s < 4; s++)
      for (int i = 0; i < d; i++) begin
        c_s[s][i] = 8'h00;
        for (int j = 0; j < d; j++) c_s[s][i] = c_s[s][i] ^ t_q[s][i][j];
      end
  end

  always_comb begin
    out_o = '0;
    for (int i = 0; i < d; i++) begin
      o_sh[i] = affine_lin(c_s[3][i]) ^ ((i == 0) ? 8'h63 : 8'h00);
      for (int j = 0; j < 8; j++) out_o[share_bit(d, 0, j, i)] = o_sh[i][j];
    end
  end

endmodule

// File: rtl/aes_sbox_dom_word.sv
// Word-level time-multiplexed front end for the DOM masked AES S-box.
// Accepts one d-share 32-bit word, feeds it through NS byte S-boxes over
// 4/NS beats, reassembles the masked result and hands it out.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   in_valid_i/in_ready_o        input handshake, in_data_i [32d] masked word
//   rnd_bus0w_i..rnd_bus3w_i     per-instance fresh randomness (slice n per instance)
//   rnd_req_o                    high in every cycle randomness is consumed
//   out_valid_o/out_ready_i      output handshake, out_data_o [32d] masked result
//
// state    | meaning
// ST_IDLE  | ready for a new word
// ST_FEED  | presenting beat k to the S-box instances, consuming randomness
// ST_DRAIN | waiting for outstanding beats to leave the pipeline
// ST_DONE  | result held until the consumer takes it
//
// LAT must equal the instance pipeline depth (4).
module aes_sbox_dom_word
  import aes_dom_pkg::*;
#(
  parameter int d   = 2,
  parameter int NS  = 1,
  parameter int LAT = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [32*d-1:0]            in_data_i,
  input  logic [NS*rnd_r0(d)-1:0]    rnd_bus0w_i,
  input  logic [NS*rnd_r1(d)-1:0]    rnd_bus1w_i,
  input  logic [NS*rnd_r2(d)-1:0]    rnd_bus2w_i,
  input  logic [NS*rnd_r3(d)-1:0]    rnd_bus3w_i,
  output logic                       rnd_req_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [32*d-1:0]            out_data_o
);

  localparam int BEATS  = 4 / NS;
  localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BYTE_W = 8 * d;
  localparam int BEAT_W = NS * BYTE_W;
  localparam int R0 = rnd_r0(d);
  localparam int R1 = rnd_r1(d);
  localparam int R2 = rnd_r2(d);
  localparam int R3 = rnd_r3(d);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  state_e            state_q, state_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [32*d-1:0]   word_q;
  logic [32*d-1:0]   out_q;
  logic [LAT-1:0]    vld_q;
  logic [BW-1:0]     idx_q [LAT];
  logic              accept;
  logic              feed;
  logic [BEAT_W-1:0] sb_in;
  logic [BEAT_W-1:0] sb_out;

  assign in_ready_o  = (state_q == ST_IDLE) && !rst_i;
  assign accept      = in_valid_i && in_ready_o;
  assign feed        = (state_q == ST_FEED);
  assign rnd_req_o   = feed;
  assign out_valid_o = (state_q == ST_DONE);
  assign out_data_o  = out_q;

  // Idle instances see all-zero shares so no word data leaks between beats.
  assign sb_in = feed ? word_q[beat_q*BEAT_W +: BEAT_W] : '0;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_FEED;
          beat_d  = '0;
        end
      end
      ST_FEED: begin
        beat_d = beat_q + BW'(1);
        if (beat_q == LAST_BEAT) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (vld_q[LAT-1] && (idx_q[LAT-1] == LAST_BEAT)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // Beat tracker mirrors the S-box pipeline; its tap marks which result
  // bytes the instances are producing this cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      word_q <= '0;
      out_q  <= '0;
      vld_q  <= '0;
      for (int i = 0; i < LAT; i++) idx_q[i] <= '0;
    end else begin
      if (accept) word_q <= in_data_i;
      vld_q[0] <= feed;
      idx_q[0] <= beat_q;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
      if (vld_q[LAT-1]) out_q[idx_q[LAT-1]*BEAT_W +: BEAT_W] <= sb_out;
    end
  end

  for (genvar n = 0; n < NS; n++) begin : g_sbox
    aes_sbox_dom #(.d(d)) u_sbox (
      .clk_i  (clk_i),
      .in_i   (sb_in[n*BYTE_W +: BYTE_W]),
      .rnd0_i (feed ? rnd_bus0w_i[n*R0 +: R0] : '0),
      .rnd1_i (feed ? rnd_bus1w_i[n*R1 +: R1] : '0),
      .rnd2_i (feed ? rnd_bus2w_i[n*R2 +: R2] : '0),
      .rnd3_i (feed ? rnd_bus3w_i[n*R3 +: R3] : '0),
      .out_o  (sb_out[n*BYTE_W +: BYTE_W])
    );
  end

endmodule

// File: tb/tb_aes_sbox_dom_word.sv
module tb_aes_sbox_dom_word;
  import aes_dom_pkg::*;

  localparam int NC  = 3;
  localparam int LAT = 4;

  function automatic int cfg_d(input int k);
    return (k == 2) ? 3 : 2;
  endfunction

  function automatic int cfg_ns(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 4 : 2);
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NC-1:0]       in_valid  = '0;
  logic [NC-1:0]       out_ready = '0;
  logic [NC-1:0]       in_ready, rnd_req, out_valid;
  logic [95:0]         in_data   = '0;
  logic [NC-1:0][95:0] out_data;

  for (genvar k = 0; k < NC; k++) begin : g_cfg
    localparam int D  = cfg_d(k);
    localparam int NS = cfg_ns(k);
    localparam int W0 = NS * rnd_r0(D);
    localparam int W1 = NS * rnd_r1(D);
    localparam int W2 = NS * rnd_r2(D);
    localparam int W3 = NS * rnd_r3(D);
    localparam int WT = W0 + W1 + W2 + W3;
    logic [WT-1:0]    rnd_all;
    logic [32*D-1:0]  dout;

    always @(negedge clk)
      for (int b = 0; b < WT; b++) rnd_all[b] = 1'($urandom);

    aes_sbox_dom_word #(.d(D), .NS(NS), .LAT(LAT)) u_dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_valid_i  (in_valid[k]),
      .in_ready_o  (in_ready[k]),
      .in_data_i   (in_data[32*D-1:0]),
      .rnd_bus0w_i (rnd_all[W0-1:0]),
      .rnd_bus1w_i (rnd_all[W0 +: W1]),
      .rnd_bus2w_i (rnd_all[W0+W1 +: W2]),
      .rnd_bus3w_i (rnd_all[W0+W1+W2 +: W3]),
      .rnd_req_o   (rnd_req[k]),
      .out_valid_o (out_valid[k]),
      .out_ready_i (out_ready[k]),
      .out_data_o  (dout)
    );
    assign out_data[k] = 96'(dout);
  end

  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] exp_q [$];
  logic [7:0]  sbox_t [256];

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    r = 8'h00;
    for (int k = 7; k >= 0; k--) r = xt(r) ^ (b[k] ? a : 8'h00);
    return r;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    logic [7:0] c;
    c = 8'h63;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (ref_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_t[a] = s;
    end
  endtask

  function automatic logic [31:0] sbox_word(input logic [31:0] v);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[b*8 +: 8] = sbox_t[v[b*8 +: 8]];
    return r;
  endfunction

  // Share 0 carries value ^ other shares; other shares random or zero.
  function automatic logic [95:0] mask_word(input logic [31:0] v, input int d, input bit rmask);
    logic [95:0] r;
    logic [7:0]  acc, sh;
    r = '0;
    for (int b = 0; b < 4; b++) begin
      acc = v[b*8 +: 8];
      for (int i = d - 1; i >= 0; i--) begin
        if (i == 0) sh = acc;
        else begin
          sh  = rmask ? 8'($urandom) : 8'h00;
          acc = acc ^ sh;
        end
        for (int j = 0; j < 8; j++) r[b*8*d + j*d + i] = sh[j];
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] unmask(input logic [95:0] w, input int d);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 4; b++)
      for (int j = 0; j < 8; j++)
        for (int i = 0; i < d; i++) r[b*8 + j] = r[b*8 + j] ^ w[b*8*d + j*d + i];
    return r;
  endfunction

  task automatic run_word(input int k, input logic [31:0] v, input bit rmask,
                          input logic [31:0] exp, input int hold, input bit early);
    int cyc, rq;
    bit busy_ok, stable_ok;
    logic [95:0] held;
    logic [31:0] want;
    exp_q.push_back(exp);
    check($sformatf("in_ready_idle_k%0d", k), 96'(in_ready[k]), 96'(1'b1));
    in_data      = mask_word(v, cfg_d(k), rmask);
    in_valid[k]  = 1'b1;
    out_ready[k] = early;
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    cyc = 0; rq = 0; busy_ok = 1'b1;
    while (!out_valid[k] && cyc < 40) begin
      if (rnd_req[k]) rq++;
      if (in_ready[k]) busy_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    check($sformatf("latency_k%0d", k), 96'(cyc), 96'(4 / cfg_ns(k) + LAT));
    check($sformatf("rnd_req_cycles_k%0d", k), 96'(rq), 96'(4 / cfg_ns(k)));
    check($sformatf("in_ready_busy_k%0d", k), 96'(busy_ok), 96'(1'b1));
    held = out_data[k];
    stable_ok = 1'b1;
    for (int h = 0; h < hold; h++) begin
      in_valid[k] = 1'b1;
      in_data     = mask_word(32'($urandom), cfg_d(k), 1'b1);
      @(posedge clk); #1;
      if (out_data[k] !== held || !out_valid[k] || in_ready[k]) stable_ok = 1'b0;
    end
    in_valid[k] = 1'b0;
    if (hold > 0) check($sformatf("backpressure_hold_k%0d", k), 96'(stable_ok), 96'(1'b1));
    want = exp_q.pop_front();
    check($sformatf("result_k%0d_%08h", k, v), 96'(unmask(out_data[k], cfg_d(k))), 96'(want));
    out_ready[k] = 1'b1;
    @(posedge clk); #1;
    out_ready[k] = 1'b0;
    check($sformatf("out_valid_drop_k%0d", k), 96'(out_valid[k]), 96'(1'b0));
  endtask

  initial begin
    logic [31:0] w;
    bit zero_ok;
    build_sbox();
    @(posedge clk); #1;
    check("in_ready_in_reset", 96'(in_ready), 96'(3'b000));
    check("out_valid_reset", 96'(out_valid), 96'(3'b000));
    check("rnd_req_reset", 96'(rnd_req), 96'(3'b000));
    check("out_data_reset_k0", out_data[0], 96'(0));
    check("out_data_reset_k2", out_data[2], 96'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    check("in_ready_after_reset", 96'(in_ready), 96'(3'b111));

    run_word(1, 32'h00112233, 1'b0, 32'h638293C3, 0, 1'b0);
    run_word(0, 32'h00112233, 1'b1, 32'h638293C3, 0, 1'b0);
    run_word(0, 32'h00FF5301, 1'b1, 32'h6316ED7C, 10, 1'b0);
    run_word(0, 32'h00112233, 1'b1, 32'h638293C3, 0, 1'b1);
    run_word(2, 32'hFFFFFFFF, 1'b1, 32'h16161616, 0, 1'b0);

    // Reset while instance 0 is draining: nothing stale may land afterwards.
    in_data     = mask_word(32'hA5C3F00F, 2, 1'b1);
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("out_valid_after_mid_reset", 96'(out_valid[0]), 96'(1'b0));
    check("out_data_after_mid_reset", out_data[0], 96'(0));
    check("rnd_req_after_mid_reset", 96'(rnd_req[0]), 96'(1'b0));
    rst = 1'b0;
    zero_ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (out_valid[0] || out_data[0] !== 96'(0)) zero_ok = 1'b0;
    end
    check("no_stale_capture", 96'(zero_ok), 96'(1'b1));
    run_word(0, 32'h00112233, 1'b1, 32'h638293C3, 0, 1'b0);

    for (int k = 0; k < NC; k++)
      for (int v = 0; v < 256; v++) begin
        for (int b = 0; b < 4; b++) w[b*8 +: 8] = 8'(v + 61 * b);
        run_word(k, w, 1'b1, sbox_word(w), 0, 1'b0);
      end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
